// File: rtl/rv_pkg.sv
// Shared register-file definitions: default widths and the write-back entry payload.
package rv_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rv_wb_fifo.sv
// Write-back queue: circular buffer of wb_entry_t with occupancy count.
// Exposes every slot and its valid bit so the top level can search for bypass hits.
module rv_wb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  wb_entry_t                      push_entry,
    input  logic                           pop,
    output wb_entry_t                      head,
    output wb_entry_t [DEPTH-1:0]          entries,
    output logic [DEPTH-1:0]               entry_valid,
    output logic [$clog2(DEPTH)-1:0]       head_idx,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_valid[i] = CW'(PW'(PW'(i) - rd_ptr)) < count;
        end
    end

    assign head     = mem[rd_ptr];
    assign entries  = mem;
    assign head_idx = rd_ptr;

endmodule

// File: rtl/rv_reg_writeback.sv
// Write-side front end of the register file: round-robin ALU/LSU arbitration into a
// write queue, registered write port, and youngest-first bypass for in-flight writes.
module rv_reg_writeback #(
    parameter int unsigned DATA_WIDTH = rv_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = rv_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_WIDTH-1:0]     alu_rd,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [ADDR_WIDTH-1:0]     lsu_rd,
    input  logic [DATA_WIDTH-1:0]     lsu_data,
    input  logic                      wb_stall,
    output logic [ADDR_WIDTH-1:0]     rd,
    output logic [DATA_WIDTH-1:0]     Rd_input,
    output logic                      we,
    input  logic [ADDR_WIDTH-1:0]     rs1,
    input  logic [ADDR_WIDTH-1:0]     rs2,
    output logic                      byp1_hit,
    output logic                      byp2_hit,
    output logic [DATA_WIDTH-1:0]     byp1_data,
    output logic [DATA_WIDTH-1:0]     byp2_data,
    output logic [$clog2(DEPTH):0]    count
);

    import rv_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic                  pop;
    logic                  space;
    logic                  grant_lsu;
    logic                  xfer;
    logic                  push;
    logic                  last_lsu;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_valid;
    logic [PW-1:0]         head_idx;
    logic [PW-1:0]         idx;

    // Arbitration: a lone valid wins; with both valid, the source not granted last time wins.
    always_comb begin
        pop             = !wb_stall && (count != '0);
        space           = (count < CW'(DEPTH)) || pop;
        grant_lsu       = lsu_valid && (!alu_valid || !last_lsu);
        alu_ready       = alu_valid && !grant_lsu && space;
        lsu_ready       = grant_lsu && space;
        xfer            = alu_ready || lsu_ready;
        push_entry.rd   = grant_lsu ? lsu_rd : alu_rd;
        push_entry.data = grant_lsu ? lsu_data : alu_data;
        push            = xfer && (push_entry.rd != '0);
    end

    // Reset to LSU so the ALU is preferred on the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lsu <= 1'b1;
        end else if (xfer) begin
            last_lsu <= grant_lsu;
        end
    end

    rv_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .entries     (entries),
        .entry_valid (entry_valid),
        .head_idx    (head_idx),
        .count       (count)
    );

    // Output stage: holds the last written index/data when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd       <= '0;
            Rd_input <= '0;
            we       <= 1'b0;
        end else if (pop) begin
            rd       <= head.rd;
            Rd_input <= head.data;
            we       <= 1'b1;
        end else begin
            we       <= 1'b0;
        end
    end

    // Bypass: output stage first, then queue oldest to youngest so the youngest match lands last.
    always_comb begin
        byp1_hit  = 1'b0;
        byp2_hit  = 1'b0;
        byp1_data = '0;
        byp2_data = '0;
        idx       = '0;
        if (we && rd == rs1 && rs1 != '0) begin
            byp1_hit  = 1'b1;
            byp1_data = Rd_input;
        end
        if (we && rd == rs2 && rs2 != '0) begin
            byp2_hit  = 1'b1;
            byp2_data = Rd_input;
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_idx + PW'(k);
            if (entry_valid[idx] && entries[idx].rd == rs1 && rs1 != '0) begin
                byp1_hit  = 1'b1;
                byp1_data = entries[idx].data;
            end
            if (entry_valid[idx] && entries[idx].rd == rs2 && rs2 != '0) begin
                byp2_hit  = 1'b1;
                byp2_data = entries[idx].data;
            end
        end
    end

endmodule

// File: doc/rv_reg_writeback.md
# rv_reg_writeback

Write-side front end of `rv_reg_file`: collects completed results from the ALU and the load/store unit, buffers them, and drives the register file's single write port (`rd`, `Rd_input`, `we`). It sits between execute/memory and the register file. It also supplies bypass data for reads that target registers with writes still in flight.

## Interface
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register index width
- `DEPTH`, 4, write-queue entries (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result available
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  ADDR_WIDTH  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `lsu_valid`  in  1  load result available
- `lsu_ready`  out  1  load result accepted this cycle
- `lsu_rd`  in  ADDR_WIDTH  load destination register
- `lsu_data`  in  DATA_WIDTH  load result
- `wb_stall`  in  1  register file write port unavailable next cycle
- `rd`  out  ADDR_WIDTH  register file write index (registered)
- `Rd_input`  out  DATA_WIDTH  register file write data (registered)
- `we`  out  1  register file write enable (registered)
- `rs1`, `rs2`  in  ADDR_WIDTH  read indices also presented to the register file
- `byp1_hit`, `byp2_hit`  out  1  pending write to `rs1`/`rs2` exists
- `byp1_data`, `byp2_data`  out  DATA_WIDTH  youngest pending data for `rs1`/`rs2`
- `count`  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Handshake: transfer occurs when valid and ready are both high at the rising edge. Valid must not depend on ready. Ready may depend on both valids.
- `pop` = `!wb_stall && count != 0`. `space` = `count < DEPTH || pop`.
- Arbitration is round-robin with a 1-bit last-grant register (reset → ALU preferred).
  - Only one source valid: that source is granted.
  - Both valid: the source not granted last time wins.
  - `x_ready` = granted && `space`. Last-grant updates only on an actual transfer.
- A transfer with rd = 0 completes the handshake but is discarded: no enqueue, and last-grant still updates.
- Push and pop in the same cycle are both performed. When full with pop, push is legal and `count` is unchanged.
- Output stage, each edge:
  - If `pop`: load the head into `rd`/`Rd_input` and set `we`=1.
  - Otherwise: set `we`=0 and hold `rd`/`Rd_input`.
- Bypass:
  - The search covers the output stage (when `we`=1) and all valid queue entries.
  - The youngest match wins: the queue tail side has priority over the head, and the queue has priority over the output stage.
  - `rs` = 0 never hits. `bypN_data` = 0 when there is no hit.
  - Bypass is purely combinational from state and `rs1`/`rs2`.
- Reset (async, any time, including mid-stall with a full queue): `count`=0, pointers 0, `we`=0, `rd`=0, `Rd_input`=0, last-grant=LSU (so ALU is preferred first). Queued data is dropped.

## Timing
- Accept at edge N → entry in queue after N → earliest `we`=1 after edge N+1 → register file updated at edge N+2.
- Each `wb_stall` cycle adds one cycle to that latency.
- Throughput: one write per cycle sustained when not stalled.
- Ready is combinational from `count`, `wb_stall`, the valids and last-grant.
- Bypass reflects the pre-edge state in the same cycle; an accept at edge N is visible on bypass during cycle N+1.
- Pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.

## Structure
- Shared package `rv_pkg`: `DATA_WIDTH`/`ADDR_WIDTH` defaults and the `wb_entry_t` {rd, data} struct; the register file uses the same definitions.
- Sub-module `rv_wb_fifo`:
  - Storage, pointers and `count`.
  - Exposes all entries plus per-entry valid bits for the bypass search.
- Arbiter, output stage and bypass live in the top level.

## Test plan
- Single ALU write rd=4, data 0x77, no stall: `alu_ready`=1 at edge 0, `we`=1/`rd`=4/`Rd_input`=0x77 for exactly one cycle after edge 1, `count` returns to 0.
- Both valid every cycle (ALU rd=1 data 0xA…, LSU rd=2 data 0xB…):
  - grants alternate ALU, LSU, ALU, …
  - output `rd` sequence 1, 2, 1, 2 with one write per cycle.
- `wb_stall`=1 with ALU pushing rd=5..9:
  - `count` reaches 4 and `alu_ready` drops on the 5th.
  - `we` stays 0 throughout.
  - Release stall: writes rd 5, 6, 7, 8, then 9 in order.
  - Full + pop + push cycle keeps `count`=4.
- Push rd=0 data 0xFF: handshake completes, `count` stays 0, `we` never asserts.
- Bypass: stall, push rd=3 data 0x11 then rd=3 data 0x22, set rs1=3, rs2=0:
  - `byp1_hit`=1 with `byp1_data`=0x22.
  - `byp2_hit`=0.
- Assert `rst_n`=0 mid-stall with `count`=3: immediately `we`=0, `count`=0, `rd`=0. After release, first grant with both valid goes to ALU.
